ahb_slave_if_p: RTL
===================

Name: ahb_slave_if_p

Overview:
- Parametrised AHB slave front-end for the AHB-APB bridge; next generation of the fixed-width 2-stage slave interface.
- Decodes transfer validity over a configurable address window split into NUM_SLV equal APB regions, and produces a one-hot select.
- Pipelines address, write data, write flag and per-stage valid/select through PIPE_DEPTH stages that stall on HREADYIN.
- Adds an AHB two-cycle ERROR response for active transfers outside the window.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
NUM_SLV, 4, number of APB regions / select bits (1..16)
BASE, 32'h8000_0000, window base address; must be aligned to SLV_SIZE
SLV_SIZE, 32'h0400_0000, bytes per region; power of two
PIPE_DEPTH, 2, pipeline stages (1..8)

Ports:
HCLK  in  1  bus clock; all logic on rising edge
HRESET  in  1  synchronous, active-high reset
HWRITE  in  1  transfer direction, 1 = write
HREADYIN  in  1  bus ready; pipeline advances only when 1
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HADDR  in  ADDR_W  transfer address
HWDATA  in  DATA_W  write data
VALID  out  1  combinational: active in-window transfer this cycle
TEMP_SEL  out  NUM_SLV  combinational one-hot region select; 0 when VALID=0
PIPEA  out  ADDR_W*PIPE_DEPTH  address stages; stage k at [k*ADDR_W +: ADDR_W], stage 0 newest
PIPED  out  DATA_W*PIPE_DEPTH  write-data stages, same packing
HWRITEREG  out  PIPE_DEPTH  registered HWRITE per stage
VALIDREG  out  PIPE_DEPTH  registered VALID per stage
SELREG  out  NUM_SLV*PIPE_DEPTH  registered TEMP_SEL per stage
HREADYOUT  out  1  slave ready
HRESP  out  1  0 OKAY, 1 ERROR

Behaviour:
- Active transfer: HTRANS is 10 or 11, AND HREADYIN=1. IDLE and BUSY are never active.
- In-window: BASE <= HADDR < BASE + NUM_SLV*SLV_SIZE. Compare at ADDR_W+1 bits, so a window reaching 2^ADDR_W does not wrap.
- VALID = active AND in-window.
- TEMP_SEL[i] = VALID AND (HADDR - BASE) / SLV_SIZE == i. Exactly one bit is set when VALID=1.
- Pipeline registers, when HREADYIN=1:
  - stage0 <= {HADDR, HWDATA, HWRITE, VALID, TEMP_SEL}
  - stage k <= stage k-1
- When HREADYIN=0, all stages hold.
- Latency: the input appears at stage k output k+1 clocks after sampling.
- Out-of-window and idle cycles still shift, with VALIDREG=0 and SELREG=0.
- Error FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Moves to ERR1 on an active transfer that is not in-window; otherwise stays.
  - ERR1: HREADYOUT=0, HRESP=1. Always moves to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Moves to ERR1 if another active out-of-window transfer is sampled (back-to-back errors); otherwise moves to IDLE.
- The FSM never affects pipeline shifting. The bus drives HREADYIN from HREADYOUT, so a stall follows naturally.
- HRESET=1 at a clock edge:
  - All PIPEA, PIPED, HWRITEREG, VALIDREG and SELREG go to 0.
  - FSM goes to IDLE, so HREADYOUT=1 and HRESP=0.
  - Reset overrides everything, including mid-error and mid-stall.
- VALID and TEMP_SEL follow the inputs combinationally during reset.
- Address HADDR = BASE + NUM_SLV*SLV_SIZE - 1 selects region NUM_SLV-1.
- Addresses BASE-1 and BASE + NUM_SLV*SLV_SIZE are out of window.

Test Plan:
- Reset with inputs toggling:
  - HRESET=1 for 2 clocks -> all registered outputs 0, HREADYOUT=1, HRESP=0.
  - Release -> first NONSEQ write to 32'h8000_0010, data 32'hA5A5_0001.
  - VALID=1, TEMP_SEL=4'b0001.
  - Stage0 holds the transfer after 1 clock; stage1 after 2 clocks, with HWRITEREG[1]=1.
- Region boundaries with defaults:
  - 32'h83FF_FFFF -> TEMP_SEL=0001.
  - 32'h8400_0000 -> 0010.
  - 32'h8FFF_FFFF -> 1000.
  - 32'h9000_0000 -> VALID=0, TEMP_SEL=0.
  - 32'h7FFF_FFFF -> VALID=0, TEMP_SEL=0.
- HTRANS gating: in-window address with HTRANS=00, and again with HTRANS=01 -> VALID=0 and FSM stays IDLE. With HTRANS=11 and HREADYIN=0 -> VALID=0.
- Stall: stream 3 SEQ transfers, then drive HREADYIN=0 for 3 clocks -> PIPEA and PIPED hold. On HREADYIN=1 they resume with no lost or duplicated stage.
- Error response:
  - NONSEQ to 32'h9000_0000 -> next clock HREADYOUT=0, HRESP=1; following clock HREADYOUT=1, HRESP=1; then IDLE.
  - A second bad NONSEQ sampled in ERR2 -> ERR1 again.
  - HRESET asserted while in ERR1 -> IDLE on the next clock.
- Parameter sweep:
  - NUM_SLV=8, PIPE_DEPTH=4, ADDR_W=32, BASE=32'hF000_0000, SLV_SIZE=32'h0200_0000 -> 32'hFFFF_FFFC gives TEMP_SEL bit 7, with no wrap.
  - The same transfer reaches stage 3 after 4 clocks.

Source files
------------

// File: rtl/ahb_slave_if_p.sv
// AHB slave front-end for the AHB-APB bridge: window decode, one-hot region select,
// a stallable multi-stage transfer pipeline and a two-cycle ERROR response.
module ahb_slave_if_p #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       NUM_SLV    = 4,
  parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLV_SIZE   = 32'h0400_0000,
  parameter int unsigned       PIPE_DEPTH = 2
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic                         HWRITE,
  input  logic                         HREADYIN,
  input  logic [1:0]                   HTRANS,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [DATA_W-1:0]            HWDATA,
  output logic                         VALID,
  output logic [NUM_SLV-1:0]           TEMP_SEL,
  output logic [ADDR_W*PIPE_DEPTH-1:0] PIPEA,
  output logic [DATA_W*PIPE_DEPTH-1:0] PIPED,
  output logic [PIPE_DEPTH-1:0]        HWRITEREG,
  output logic [PIPE_DEPTH-1:0]        VALIDREG,
  output logic [NUM_SLV*PIPE_DEPTH-1:0] SELREG,
  output logic                         HREADYOUT,
  output logic                         HRESP
);

  localparam int unsigned     SHIFT  = $clog2(SLV_SIZE);
  // Window bounds carry one extra bit so a window ending at 2^ADDR_W does not wrap.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(NUM_SLV) * {1'b0, SLV_SIZE};

  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_e;

  state_e              state_q, state_d;
  logic                active, in_win, bad;
  logic [ADDR_W:0]     haddr_x;
  logic [ADDR_W-1:0]   off, idx;

  logic [ADDR_W-1:0]   addr_q  [PIPE_DEPTH];
  logic [DATA_W-1:0]   data_q  [PIPE_DEPTH];
  logic [NUM_SLV-1:0]  sel_q   [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] wr_q, vld_q;

  always_comb begin
    active  = ((HTRANS == 2'b10) || (HTRANS == 2'b11)) && HREADYIN;
    haddr_x = {1'b0, HADDR};
    in_win  = (haddr_x >= WIN_LO) && (haddr_x < WIN_HI);
    bad     = active && !in_win;
    VALID   = active && in_win;
    off     = HADDR - BASE;
    idx     = off >> SHIFT;
    TEMP_SEL = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++)
      TEMP_SEL[i] = VALID && (idx == ADDR_W'(i));
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
        sel_q[k]  <= '0;
      end
      wr_q  <= '0;
      vld_q <= '0;
    end else if (HREADYIN) begin
      addr_q[0] <= HADDR;
      data_q[0] <= HWDATA;
      sel_q[0]  <= TEMP_SEL;
      wr_q[0]   <= HWRITE;
      vld_q[0]  <= VALID;
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
        addr_q[k] <= addr_q[k-1];
        data_q[k] <= data_q[k-1];
        sel_q[k]  <= sel_q[k-1];
        wr_q[k]   <= wr_q[k-1];
        vld_q[k]  <= vld_q[k-1];
      end
    end
  end

  always_comb begin
    PIPEA  = '0;
    PIPED  = '0;
    SELREG = '0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      PIPEA[k*ADDR_W +: ADDR_W]   = addr_q[k];
      PIPED[k*DATA_W +: DATA_W]   = data_q[k];
      SELREG[k*NUM_SLV +: NUM_SLV] = sel_q[k];
    end
    HWRITEREG = wr_q;
    VALIDREG  = vld_q;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      S_IDLE: if (bad) state_d = S_ERR1;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        HRESP   = 1'b1;
        state_d = bad ? S_ERR1 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
